// File: rtl/noc_sched_pkg.sv
// Shared types for the 2-VC link scheduler: VC index type and FSM states.
package noc_sched_pkg;

    localparam int NUM_VC = 2;

    typedef logic vc_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/vc_credit_counter.sv
// Per-VC downstream credit counter: decrements on pop, increments on credit return,
// saturates at CREDITS and raises a sticky overflow on an unexpected return.
module vc_credit_counter #(
    parameter  int CREDITS = 4,
    localparam int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          sclr,
    input  logic          dec,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          nonzero,
    output logic          overflow
);

    always_ff @(posedge clk) begin
        if (sclr) begin
            cnt      <= CW'(CREDITS);
            overflow <= 1'b0;
        end else begin
            unique case ({inc, dec})
                2'b10: begin
                    if (cnt == CW'(CREDITS)) overflow <= 1'b1;
                    else                     cnt      <= cnt + 1'b1;
                end
                2'b01: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign nonzero = (cnt != '0);

endmodule

// File: rtl/vc_link_scheduler.sv
// Packet-atomic 2-VC link scheduler with per-VC credit flow control.
// Build option: VC_SCHED_STRICT_PRI_EN gives VC1 strict priority at packet boundaries
// instead of round-robin.
//
// state  | meaning
// IDLE   | at a packet boundary; arbitrate between eligible VCs
// LOCKED | mid-packet; only lock_vc may be popped until its tail flit
module vc_link_scheduler
    import noc_sched_pkg::*;
#(
    parameter int WIDTH   = 512,
    parameter int CREDITS = 4
) (
    input  logic              clk,
    input  logic              sclr,
    input  logic [WIDTH-1:0]  fifo_q [NUM_VC],
    input  logic [NUM_VC-1:0] fifo_last,
    input  logic [NUM_VC-1:0] fifo_empty,
    output logic [NUM_VC-1:0] fifo_rdreq,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    output vc_t               out_vc,
    output logic              out_last,
    input  logic [NUM_VC-1:0] credit_ret,
    output logic              credit_err
);

    localparam int CW = $clog2(CREDITS + 1);

    state_t            state, state_nxt;
    vc_t               lock_vc, lock_vc_nxt;
    vc_t               rr_ptr, rr_ptr_nxt;
    vc_t               gnt_vc;
    logic              pop;
    logic [NUM_VC-1:0] nonzero, overflow, eligible;
    // counter values are kept as named nets so they stay visible for debug
    logic [CW-1:0]     cnt_unused0, cnt_unused1;

    vc_credit_counter #(.CREDITS(CREDITS)) u_cnt0 (
        .clk      (clk),
        .sclr     (sclr),
        .dec      (fifo_rdreq[0]),
        .inc      (credit_ret[0]),
        .cnt      (cnt_unused0),
        .nonzero  (nonzero[0]),
        .overflow (overflow[0])
    );

    vc_credit_counter #(.CREDITS(CREDITS)) u_cnt1 (
        .clk      (clk),
        .sclr     (sclr),
        .dec      (fifo_rdreq[1]),
        .inc      (credit_ret[1]),
        .cnt      (cnt_unused1),
        .nonzero  (nonzero[1]),
        .overflow (overflow[1])
    );

    assign eligible   = ~fifo_empty & nonzero;
    assign credit_err = |overflow;

    // grant selection for both arbitration policies
    always_comb begin
        pop    = 1'b0;
        gnt_vc = 1'b0;
        if (!sclr) begin
            if (state == LOCKED) begin
                gnt_vc = lock_vc;
                pop    = eligible[lock_vc];
            end else begin
`ifdef VC_SCHED_STRICT_PRI_EN
                if (eligible[1]) begin
                    gnt_vc = 1'b1;
                    pop    = 1'b1;
                end else if (eligible[0]) begin
                    gnt_vc = 1'b0;
                    pop    = 1'b1;
                end
`else
                if (eligible[rr_ptr]) begin
                    gnt_vc = rr_ptr;
                    pop    = 1'b1;
                end else if (eligible[~rr_ptr]) begin
                    gnt_vc = ~rr_ptr;
                    pop    = 1'b1;
                end
`endif
            end
        end
    end

    assign fifo_rdreq = pop ? (NUM_VC'(1) << gnt_vc) : '0;

    always_comb begin
        state_nxt   = state;
        lock_vc_nxt = lock_vc;
        rr_ptr_nxt  = rr_ptr;
        if (pop) begin
            if (fifo_last[gnt_vc]) begin
                state_nxt  = IDLE;
                rr_ptr_nxt = ~gnt_vc;
            end else begin
                state_nxt   = LOCKED;
                lock_vc_nxt = gnt_vc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state   <= IDLE;
            lock_vc <= 1'b0;
            rr_ptr  <= 1'b0;
        end else begin
            state   <= state_nxt;
            lock_vc <= lock_vc_nxt;
            rr_ptr  <= rr_ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_vc    <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= pop;
            if (pop) begin
                out_data <= fifo_q[gnt_vc];
                out_vc   <= gnt_vc;
                out_last <= fifo_last[gnt_vc];
            end
        end
    end

endmodule

// File: tb/tb_vc_link_scheduler.sv
// Directed bench for vc_link_scheduler with a show-ahead FIFO model per VC.
module tb_vc_link_scheduler;
    import noc_sched_pkg::*;

    localparam int W  = 512;
    localparam int CR = 4;

    logic          clk = 1'b0;
    logic          sclr;
    logic [W-1:0]  fifo_q [2];
    logic [1:0]    fifo_last, fifo_empty, fifo_rdreq, credit_ret;
    logic [W-1:0]  out_data;
    logic          out_valid, out_last, credit_err;
    vc_t           out_vc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vc_link_scheduler #(.WIDTH(W), .CREDITS(CR)) dut (
        .clk        (clk),
        .sclr       (sclr),
        .fifo_q     (fifo_q),
        .fifo_last  (fifo_last),
        .fifo_empty (fifo_empty),
        .fifo_rdreq (fifo_rdreq),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_vc     (out_vc),
        .out_last   (out_last),
        .credit_ret (credit_ret),
        .credit_err (credit_err)
    );

    // show-ahead FIFO model
    logic [W-1:0] mem_d [2][16];
    logic         mem_l [2][16];
    logic [3:0]   head [2];
    logic [3:0]   tail [2];
    logic [1:0]   flush;

    initial begin
        head[0] = '0; head[1] = '0;
        tail[0] = '0; tail[1] = '0;
    end

    assign fifo_q[0]     = mem_d[0][head[0]];
    assign fifo_q[1]     = mem_d[1][head[1]];
    assign fifo_last[0]  = mem_l[0][head[0]];
    assign fifo_last[1]  = mem_l[1][head[1]];
    assign fifo_empty[0] = (head[0] == tail[0]);
    assign fifo_empty[1] = (head[1] == tail[1]);

    always @(posedge clk) begin
        for (int v = 0; v < 2; v++) begin
            if (flush[v])           head[v] <= tail[v];
            else if (fifo_rdreq[v]) head[v] <= head[v] + 4'd1;
        end
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int v, input logic [W-1:0] d, input logic l);
        mem_d[v][tail[v]] = d;
        mem_l[v][tail[v]] = l;
        tail[v] = tail[v] + 4'd1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        sclr       = 1'b1;
        flush      = 2'b11;
        credit_ret = 2'b00;
        next_cycle();
        flush = 2'b00;
        next_cycle();
        sclr = 1'b0;
    endtask

    // REQ-031 style packet: expected per-cycle values, cycles 1..5
    logic [1:0]   t1_rd   [5] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    logic         t1_val  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic         t1_lst  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] t1_dat  [5] = '{W'(0), W'('hA0), W'('hA1), W'('hA2), W'('hA2)};

    // two 2-flit packets, cycles 1..6
`ifdef VC_SCHED_STRICT_PRI_EN
    logic [1:0]   t2_rd  [6] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00};
    logic         t2_vc  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [W-1:0] t2_dat [6] = '{W'(0), W'('hB0), W'('hB1), W'('hA0), W'('hA1), W'('hA1)};
    logic [1:0]   t3_rd  [4] = '{2'b10, 2'b10, 2'b10, 2'b01};
    logic         t3_vc  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
`else
    logic [1:0]   t2_rd  [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
    logic         t2_vc  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] t2_dat [6] = '{W'(0), W'('hA0), W'('hA1), W'('hB0), W'('hB1), W'('hB1)};
    logic [1:0]   t3_rd  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic         t3_vc  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    logic         t2_val [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic         t2_lst [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           n_val;
        int           n_vc1;
        logic [W-1:0] last_dat;

        sclr       = 1'b1;
        credit_ret = 2'b00;
        flush      = 2'b00;
        next_cycle();
        next_cycle();

        // reset state, rdreq held low and credit_ret ignored during reset
        push(0, W'('hA0), 1'b0);
        push(0, W'('hA1), 1'b0);
        push(0, W'('hA2), 1'b1);
        credit_ret = 2'b01;
        settle();
        check("rst_rdreq",     W'(fifo_rdreq), W'(0));
        check("rst_out_valid", W'(out_valid),  W'(0));
        check("rst_out_data",  out_data,       W'(0));
        check("rst_out_vc",    W'(out_vc),     W'(0));
        check("rst_out_last",  W'(out_last),   W'(0));
        check("rst_state",     W'(dut.state),  W'(IDLE));
        next_cycle();
        credit_ret = 2'b00;
        settle();
        check("rst_cnt0_ign",  W'(dut.u_cnt0.cnt), W'(CR));
        check("rst_cnt1",      W'(dut.u_cnt1.cnt), W'(CR));
        check("rst_err",       W'(credit_err),     W'(0));

        // 3-flit packet on VC0
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            if (k == 0) sclr = 1'b0;
            settle();
            check($sformatf("p3_rdreq_c%0d", k + 1), W'(fifo_rdreq), W'(t1_rd[k]));
            check($sformatf("p3_valid_c%0d", k + 1), W'(out_valid),  W'(t1_val[k]));
            check($sformatf("p3_last_c%0d",  k + 1), W'(out_valid & out_last), W'(t1_lst[k]));
            if (k > 0) check($sformatf("p3_data_c%0d", k + 1), out_data, t1_dat[k]);
        end
        check("p3_cnt0",  W'(dut.u_cnt0.cnt), W'(1));
        check("p3_state", W'(dut.state),      W'(IDLE));
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            credit_ret = 2'b01;
        end
        next_cycle();
        credit_ret = 2'b00;
        settle();
        check("p3_cnt0_refill", W'(dut.u_cnt0.cnt), W'(CR));

        // unexpected credit return at full count
        do_reset();
        credit_ret = 2'b10;
        next_cycle();
        credit_ret = 2'b00;
        settle();
        check("ovf_cnt1", W'(dut.u_cnt1.cnt), W'(CR));
        check("ovf_err",  W'(credit_err),     W'(1));
        for (int k = 0; k < 3; k++) next_cycle();
        check("ovf_err_sticky", W'(credit_err), W'(1));
        sclr = 1'b1;
        next_cycle();
        sclr = 1'b0;
        settle();
        check("ovf_err_clr", W'(credit_err), W'(0));

        // two 2-flit packets, no interleave
        do_reset();
        next_cycle();
        push(0, W'('hA0), 1'b0);
        push(0, W'('hA1), 1'b1);
        push(1, W'('hB0), 1'b0);
        push(1, W'('hB1), 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) next_cycle();
            settle();
            check($sformatf("pp_rdreq_c%0d", k + 1), W'(fifo_rdreq), W'(t2_rd[k]));
            check($sformatf("pp_valid_c%0d", k + 1), W'(out_valid),  W'(t2_val[k]));
            if (t2_val[k]) begin
                check($sformatf("pp_vc_c%0d",   k + 1), W'(out_vc),   W'(t2_vc[k]));
                check($sformatf("pp_last_c%0d", k + 1), W'(out_last), W'(t2_lst[k]));
                check($sformatf("pp_data_c%0d", k + 1), out_data,     t2_dat[k]);
            end
        end

        // continuous single-flit packets on both VCs
        do_reset();
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            push(0, W'('hC0 + i), 1'b1);
            push(1, W'('hD0 + i), 1'b1);
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) next_cycle();
            settle();
            if (k < 4) check($sformatf("sf_rdreq_c%0d", k + 1), W'(fifo_rdreq), W'(t3_rd[k]));
            if (k > 0) begin
                check($sformatf("sf_valid_c%0d", k + 1), W'(out_valid), W'(1));
                check($sformatf("sf_vc_c%0d",    k + 1), W'(out_vc),    W'(t3_vc[k-1]));
            end
            if (k < 4) check($sformatf("sf_state_c%0d", k + 1), W'(dut.state), W'(IDLE));
        end

        // credit exhaustion mid-packet, VC1 must wait
        do_reset();
        next_cycle();
        for (int i = 0; i < 6; i++) push(0, W'('hE0 + i), (i == 5));
        n_val = 0;
        n_vc1 = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) next_cycle();
            if (k == 2) push(1, W'('hF0), 1'b1);
            settle();
            if (out_valid) n_val++;
            if (fifo_rdreq[1] || (out_valid && out_vc)) n_vc1++;
        end
        check("cx_flits",    W'(n_val),            W'(4));
        check("cx_no_vc1",   W'(n_vc1),            W'(0));
        check("cx_cnt0",     W'(dut.u_cnt0.cnt),   W'(0));
        check("cx_locked",   W'(dut.state),        W'(LOCKED));
        next_cycle();
        credit_ret = 2'b01;
        settle();
        check("cx_no_pop_at_zero", W'(fifo_rdreq), W'(0));
        n_val    = 0;
        last_dat = '0;
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            credit_ret = 2'b00;
            settle();
            if (out_valid) begin
                n_val++;
                last_dat = out_data;
            end
            if (fifo_rdreq[1] || (out_valid && out_vc)) n_vc1++;
        end
        check("cx_one_more",  W'(n_val),    W'(1));
        check("cx_one_data",  last_dat,     W'('hE4));
        check("cx_no_vc1_2",  W'(n_vc1),    W'(0));
        check("cx_locked_2",  W'(dut.state), W'(LOCKED));
        do_reset();
        settle();
        check("cx_rst_unlock", W'(dut.state), W'(IDLE));

        // simultaneous pop and credit return
        do_reset();
        next_cycle();
        push(0, W'('h90), 1'b0);
        push(0, W'('h91), 1'b0);
        settle();
        check("sc_pop1", W'(fifo_rdreq), W'(2'b01));
        next_cycle();
        next_cycle();
        settle();
        check("sc_cnt0_2",  W'(dut.u_cnt0.cnt), W'(2));
        check("sc_stall",   W'(fifo_rdreq),     W'(0));
        push(0, W'('h92), 1'b1);
        credit_ret = 2'b01;
        settle();
        check("sc_pop_tail", W'(fifo_rdreq), W'(2'b01));
        next_cycle();
        credit_ret = 2'b00;
        settle();
        check("sc_cnt0_hold", W'(dut.u_cnt0.cnt), W'(2));
        check("sc_state",     W'(dut.state),      W'(IDLE));
        check("sc_tail_out",  W'(out_valid & out_last), W'(1));
        check("sc_tail_data", out_data,           W'('h92));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vc_link_scheduler.md
VC_LINK_SCHEDULER -- requirements
Module: vc_link_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 512, flit data width.
REQ-002 SHALL have parameter CREDITS, default 4, downstream buffer slots per VC (>=1).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port sclr  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port fifo_q[2]  input  WIDTH  head flit per VC from the 2-VC FIFO (show-ahead).
REQ-006 SHALL have port fifo_last[2]  input  1  head flit per VC is a packet tail.
REQ-007 SHALL have port fifo_empty[2]  input  1  per-VC FIFO empty.
REQ-008 SHALL have port fifo_rdreq[2]  output  1  per-VC pop, combinational, at most one high per cycle.
REQ-009 SHALL have ports out_data (WIDTH), out_valid (1), out_vc (1), out_last (1), all outputs: registered link flit, its VC and tail flag.
REQ-010 SHALL have port credit_ret[2]  input  1  one-cycle pulse per freed downstream slot per VC.
REQ-011 SHALL have port credit_err  output  1  sticky credit-overflow flag.

Function
REQ-012 SHALL hold per-VC credit counters of width $clog2(CREDITS+1); eligible[v] = !fifo_empty[v] && cnt[v] != 0.
REQ-013 SHALL implement FSM with states IDLE and LOCKED; LOCKED stores the locked VC.
REQ-014 IDLE: when any VC is eligible, SHALL grant one VC (REQ-016/REQ-030), assert its fifo_rdreq in the same cycle, and go to LOCKED unless the popped flit has fifo_last=1.
REQ-015 LOCKED: SHALL pop only the locked VC, only when it is eligible; a pop with fifo_last=1 SHALL return to IDLE; the other VC is never popped while LOCKED (packets never interleave).
REQ-016 Round-robin pointer SHALL prefer the VC not granted last; SHALL update only on tail pop.
REQ-017 A pop in cycle N SHALL produce out_valid=1 with out_data=fifo_q, out_vc, out_last=fifo_last in cycle N+1 (latency 1); otherwise out_valid=0, other outputs hold.
REQ-018 A pop SHALL decrement cnt[v]; credit_ret[v] SHALL increment it; both in one cycle SHALL leave it unchanged.
REQ-019 credit_ret[v] with cnt[v]==CREDITS and no pop SHALL saturate the counter and set credit_err until reset.
REQ-020 Stalled locked VC (empty or zero credits) SHALL produce idle cycles; no preemption, no timeout.
REQ-021 Single-flit packet (fifo_last=1 on the first flit) SHALL stay IDLE and advance the pointer.

Reset
REQ-022 sclr SHALL set state IDLE, pointer to VC0-preferred, cnt[0]=cnt[1]=CREDITS, credit_err=0, out_valid=0, out_data=0, out_vc=0, out_last=0.
REQ-023 During sclr fifo_rdreq SHALL be 0 and credit_ret SHALL be ignored.
REQ-024 sclr mid-packet SHALL drop the lock; flush of the FIFO and downstream is the caller's responsibility.

Configuration
REQ-025 Macro VC_SCHED_STRICT_PRI_EN SHALL select the IDLE arbitration policy.
REQ-026 Without the macro, IDLE grants SHALL be round-robin per REQ-016.
REQ-027 With the macro, IDLE grants SHALL give VC1 strict priority over VC0 at packet boundaries; the pointer is unused; LOCKED behaviour is unchanged.

Structure
REQ-028 Package noc_sched_pkg SHALL hold NUM_VC=2, typedef vc_t (1 bit) and the FSM state enum.
REQ-029 Sub-module vc_credit_counter (one per VC, parameter CREDITS, inputs dec/inc/sclr, outputs cnt, nonzero, overflow) SHALL implement REQ-018/REQ-019.
REQ-030 Grant selection SHALL be one combinational always block shared by both policies.

Verification
REQ-031 Reset, VC0 holds 3-flit packet, VC1 empty -> rdreq[0] in cycles 1-3, out_valid cycles 2-4, out_last only in cycle 4, cnt[0]=1.
REQ-032 Both VCs hold 2-flit packets (RR build) -> VC0 A0,A1 then VC1 B0,B1 back-to-back, no interleave, 4 consecutive out_valid.
REQ-033 CREDITS=4, VC0 holds 6 flits in one packet, no credit_ret -> 4 flits sent, stall with state LOCKED, VC1 not served even if eligible; one credit_ret[0] pulse -> exactly one more flit.
REQ-034 cnt[0]=2, same-cycle pop and credit_ret[0] -> cnt[0] stays 2.
REQ-035 credit_ret[1] pulse right after reset -> cnt[1] stays 4, credit_err=1 until sclr.
REQ-036 VC_SCHED_STRICT_PRI_EN defined, both VCs continuously hold 1-flit packets -> only VC1 granted; undefined -> grants alternate 0,1,0,1.
